// File: rtl/lsu_ctrl_if.sv
// Request/response bus between the execute stage and lsu_ctrl, and the
// 32-bit big-endian data memory port driven by lsu_ctrl.
interface lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface lsu_mem_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wenable;
  logic        mem_renable;
  logic [31:0] mem_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_wenable, mem_renable,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_wenable, mem_renable,
    output mem_rdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store controller: bounds check, read-modify-write sub-word stores,
// lane extraction for loads. Define LSU_MISALIGN_TRAP_EN to reject misaligned halves/words.
module lsu_ctrl #(
  parameter int unsigned MEM_BYTES = 16
) (
  input  logic       clk,
  input  logic       rst,
  lsu_req_if.slave   req,
  lsu_mem_if.master  mem
);

  typedef enum logic [2:0] {IDLE, RD, RDW, WR, RESP} state_t;

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);
  localparam logic [31:0] BASE_MAX  = 32'(MEM_BYTES - 4);

  state_t      state, state_next;

  logic [2:0]  req_nbytes;
  logic        req_misalign;
  logic        req_err;
  logic [31:0] req_base;
  logic [1:0]  req_k;

  logic        we_q, signed_q, err_q;
  logic [2:0]  nb_q;
  logic [1:0]  k_q;
  logic [31:0] wdata_q, rdata_q, mem_addr_q, mem_wdata_q;

  logic [1:0]  lanes_below;
  logic [4:0]  shift;
  logic [31:0] shifted, lane_mask, load_val, merged;

  always_comb begin
    req_nbytes   = 3'd4;
    req_misalign = 1'b0;
    case (req.req_size)
      2'b00:   req_nbytes = 3'd1;
      2'b01:   req_nbytes = 3'd2;
      default: req_nbytes = 3'd4;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    req_misalign = (req.req_size == 2'b01 && req.req_addr[0]) ||
                   (req.req_size == 2'b10 && req.req_addr[1:0] != 2'b00);
`else
    req_misalign = 1'b0;
`endif
    // 33-bit sum so an address near 2^32 cannot wrap back into range
    req_err  = (req.req_size == 2'b11) ||
               (({1'b0, req.req_addr} + {30'b0, req_nbytes}) > MEM_LIMIT) ||
               req_misalign;
    req_base = (req.req_addr > BASE_MAX) ? BASE_MAX : req.req_addr;
    req_k    = req.req_addr[1:0] - req_base[1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req.req_valid) begin
        if (req_err)                      state_next = RESP;
        else if (!req.req_we)             state_next = RD;
        else if (req.req_size == 2'b10)   state_next = WR;
        else                              state_next = RD;
      end
      RD:      state_next = RDW;
      RDW:     state_next = we_q ? WR : RESP;
      WR:      state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lane k of an n-byte access sits (4-k-n) bytes above the word's LSB
  always_comb begin
    lanes_below = 2'd0 - k_q - nb_q[1:0];
    shift       = {lanes_below, 3'b000};
    shifted     = mem.mem_rdata >> shift;
    case (nb_q)
      3'd1: begin
        lane_mask = 32'h0000_00FF;
        load_val  = signed_q ? {{24{shifted[7]}}, shifted[7:0]} : {24'b0, shifted[7:0]};
      end
      3'd2: begin
        lane_mask = 32'h0000_FFFF;
        load_val  = signed_q ? {{16{shifted[15]}}, shifted[15:0]} : {16'b0, shifted[15:0]};
      end
      default: begin
        lane_mask = 32'hFFFF_FFFF;
        load_val  = shifted;
      end
    endcase
    merged = (mem.mem_rdata & ~(lane_mask << shift)) | ((wdata_q & lane_mask) << shift);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q        <= 1'b0;
      signed_q    <= 1'b0;
      err_q       <= 1'b0;
      nb_q        <= 3'd0;
      k_q         <= 2'd0;
      wdata_q     <= 32'b0;
      rdata_q     <= 32'b0;
      mem_addr_q  <= 32'b0;
      mem_wdata_q <= 32'b0;
    end else begin
      if (state == IDLE && req.req_valid) begin
        we_q     <= req.req_we;
        signed_q <= req.req_signed;
        err_q    <= req_err;
        nb_q     <= req_nbytes;
        k_q      <= req_k;
        wdata_q  <= req.req_wdata;
        rdata_q  <= 32'b0;
        if (!req_err) mem_addr_q <= req_base;
        if (!req_err && req.req_we && req.req_size == 2'b10) mem_wdata_q <= req.req_wdata;
      end
      if (state == RDW) begin
        if (we_q) mem_wdata_q <= merged;
        else      rdata_q     <= load_val;
      end
    end
  end

  assign req.req_ready   = (state == IDLE);
  assign req.resp_valid  = (state == RESP);
  assign req.resp_err    = (state == RESP) && err_q;
  assign req.resp_rdata  = (state == RESP) ? rdata_q : 32'b0;
  assign mem.mem_renable = (state == RD);
  assign mem.mem_wenable = (state == WR);
  assign mem.mem_addr    = mem_addr_q;
  assign mem.mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl against a 16-byte big-endian memory model.
module tb_lsu_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_req_if req_bus ();
  lsu_mem_if mem_bus ();

  lsu_ctrl #(.MEM_BYTES(16)) dut (
    .clk (clk),
    .rst (rst),
    .req (req_bus.slave),
    .mem (mem_bus.master)
  );

  typedef struct {
    int          acc_cyc;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          rd_base;
    int          wr_base;
    int          exp_rd;
    int          exp_wr;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          rd_cnt   = 0;
  int          wr_cnt   = 0;
  logic [7:0]  tb_mem [16];
  logic [31:0] last_waddr = 32'b0;
  logic [31:0] last_wdata = 32'b0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  initial forever @(posedge clk) cyc++;

  // Big-endian memory with registered read data
  initial begin
    foreach (tb_mem[i]) tb_mem[i] = 8'h00;
    mem_bus.mem_rdata = 32'b0;
    forever begin
      @(posedge clk);
      if (mem_bus.mem_wenable) begin
        for (int i = 0; i < 4; i++)
          tb_mem[(int'(mem_bus.mem_addr[3:0]) + i) % 16] = mem_bus.mem_wdata[31-8*i -: 8];
        last_waddr = mem_bus.mem_addr;
        last_wdata = mem_bus.mem_wdata;
        wr_cnt++;
      end
      if (mem_bus.mem_renable) begin
        mem_bus.mem_rdata <= {tb_mem[int'(mem_bus.mem_addr[3:0])],
                              tb_mem[(int'(mem_bus.mem_addr[3:0]) + 1) % 16],
                              tb_mem[(int'(mem_bus.mem_addr[3:0]) + 2) % 16],
                              tb_mem[(int'(mem_bus.mem_addr[3:0]) + 3) % 16]};
        rd_cnt++;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (req_bus.resp_valid) begin
      if (sb.size() == 0) checkOutput("unexpected_resp", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
        checkOutput("resp_err", {31'b0, req_bus.resp_err}, {31'b0, e.err});
        checkOutput("resp_rdata", req_bus.resp_rdata, e.rdata);
        checkOutput("rd_pulses", 32'(rd_cnt - e.rd_base), 32'(e.exp_rd));
        checkOutput("wr_pulses", 32'(wr_cnt - e.wr_base), 32'(e.exp_wr));
      end
    end
    if (mem_bus.mem_renable && mem_bus.mem_wenable) checkOutput("both_enables", 32'd1, 32'd0);
  end

  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic exp_err, input logic [31:0] exp_rdata);
    exp_t e;
    bit   got;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_bus.req_ready) got = 1;
    end
    if (!got) begin
      checkOutput("ready_timeout", 32'd0, 32'd1);
      return;
    end
    req_bus.req_we     = we;
    req_bus.req_size   = size;
    req_bus.req_signed = sgn;
    req_bus.req_addr   = addr;
    req_bus.req_wdata  = wdata;
    req_bus.req_valid  = 1'b1;
    e.acc_cyc = cyc;
    e.err     = exp_err;
    e.rdata   = exp_rdata;
    e.rd_base = rd_cnt;
    e.wr_base = wr_cnt;
    if (exp_err)               begin e.lat = 1; e.exp_rd = 0; e.exp_wr = 0; end
    else if (!we)              begin e.lat = 3; e.exp_rd = 1; e.exp_wr = 0; end
    else if (size == 2'b10)    begin e.lat = 2; e.exp_rd = 0; e.exp_wr = 1; end
    else                       begin e.lat = 4; e.exp_rd = 1; e.exp_wr = 1; end
    sb.push_back(e);
    @(posedge clk);
    #1 req_bus.req_valid = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checkOutput("resp_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"},  {31'b0, req_bus.req_ready},     32'd1);
    checkOutput({tag, "_rvalid"}, {31'b0, req_bus.resp_valid},    32'd0);
    checkOutput({tag, "_rerr"},   {31'b0, req_bus.resp_err},      32'd0);
    checkOutput({tag, "_rdata"},  req_bus.resp_rdata,             32'd0);
    checkOutput({tag, "_maddr"},  mem_bus.mem_addr,               32'd0);
    checkOutput({tag, "_mwdata"}, mem_bus.mem_wdata,              32'd0);
    checkOutput({tag, "_wen"},    {31'b0, mem_bus.mem_wenable},   32'd0);
    checkOutput({tag, "_ren"},    {31'b0, mem_bus.mem_renable},   32'd0);
  endtask

  initial begin
    int wr_before;
    req_bus.req_valid  = 1'b0;
    req_bus.req_we     = 1'b0;
    req_bus.req_size   = 2'b00;
    req_bus.req_signed = 1'b0;
    req_bus.req_addr   = 32'b0;
    req_bus.req_wdata  = 32'b0;
    #1 checkResetValues("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    applyStimulus(1'b1, 2'b10, 1'b0, 32'd0,  32'h1122_3344, 1'b0, 32'h0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'd0,  32'h0,         1'b0, 32'h1122_3344);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'd1,  32'h0,         1'b0, 32'h0000_0022);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'd2,  32'h0,         1'b0, 32'h0000_3344);

    applyStimulus(1'b1, 2'b00, 1'b0, 32'd15, 32'hFFFF_FFAB, 1'b0, 32'h0);
    checkOutput("byte_st_waddr", last_waddr, 32'd12);
    checkOutput("byte_st_wdata", last_wdata, 32'h0000_00AB);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'd12, 32'h0,         1'b0, 32'h0000_00AB);

    applyStimulus(1'b1, 2'b01, 1'b0, 32'd14, 32'h1234_8001, 1'b0, 32'h0);
    checkOutput("half_st_wdata", last_wdata, 32'h0000_8001);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'd14, 32'h0,         1'b0, 32'hFFFF_8001);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'd14, 32'h0,         1'b0, 32'h0000_8001);

    applyStimulus(1'b0, 2'b10, 1'b0, 32'd13, 32'h0,         1'b1, 32'h0);
    applyStimulus(1'b1, 2'b11, 1'b0, 32'd0,  32'h5555_5555, 1'b1, 32'h0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'h0,  1'b1, 32'h0);

`ifdef LSU_MISALIGN_TRAP_EN
    applyStimulus(1'b1, 2'b10, 1'b0, 32'd2,  32'hDEAD_BEEF, 1'b1, 32'h0);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'd13, 32'h0,         1'b1, 32'h0);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'd2,  32'h0,         1'b0, 32'h0000_3344);
`else
    applyStimulus(1'b1, 2'b10, 1'b0, 32'd2,  32'hDEAD_BEEF, 1'b0, 32'h0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'd2,  32'h0,         1'b0, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'd13, 32'h0,         1'b0, 32'h0000_0080);
`endif
    applyStimulus(1'b0, 2'b00, 1'b1, 32'd0,  32'h0,         1'b0, 32'h0000_0011);

    // Reset lands while a sub-word store is waiting on its read data
    @(negedge clk);
    wr_before = wr_cnt;
    req_bus.req_we     = 1'b1;
    req_bus.req_size   = 2'b00;
    req_bus.req_signed = 1'b0;
    req_bus.req_addr   = 32'd0;
    req_bus.req_wdata  = 32'h0000_0055;
    req_bus.req_valid  = 1'b1;
    @(posedge clk);
    #1 req_bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 checkResetValues("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("midrst_no_write", 32'(wr_cnt - wr_before), 32'd0);
    checkOutput("midrst_mem0", {24'b0, tb_mem[0]}, 32'h0000_0011);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'd0,  32'h0,         1'b0, 32'h0000_0011);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation watchdog expired");
  end

endmodule
